morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side counterpart of the board's Morse transmitter: samples a single on/off key line, measures mark and space durations in half-second units, classifies dots and dashes, and decodes letters A–H back to the 3-bit switch code. Sits between a pushbutton or loop-back of the transmitter LED output and the display/LED logic. Operates on the board clock with no external timebase.

## Interface
- CLKS_PER_UNIT, 25000000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥ 2.
- FILTER_CLKS, 16: glitch-filter stability window in clocks; used only with MORSE_DEC_GLITCH_FILTER_EN.
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- key_in  in  1  raw key line, 1 = mark (tone/LED on); asynchronous to CLOCK_50.
- letter  out  3  last decoded letter code, A=000 … H=111; held until the next valid letter; reset 000.
- letter_valid  out  1  one-cycle pulse when letter updates; reset 0.
- letter_error  out  1  one-cycle pulse on an undecodable letter; reset 0.
- busy  out  1  1 while in MARK or SPACE; reset 0.

## Operation
- key_in passes through a 2-flop synchronizer, then the optional filter, giving k.
- Timer: sub-counter 0..CLKS_PER_UNIT-1; on wrap, 3-bit unit count increments, saturating at 7. Both cleared on every k edge and every state entry.
- Symbol register: 4 bits, LSB-first (first symbol in bit 0); dot = 0, dash = 1. 3-bit sym_cnt, plus an overflow flag.
- States: WAIT_LOW (reset state), IDLE, MARK, SPACE.
  - WAIT_LOW: k=0 → IDLE. A mark in progress at reset release is ignored.
  - IDLE: k rises → MARK; symbol register, sym_cnt and overflow cleared.
  - MARK: k falls → symbol = dash if unit count ≥ 2, else dot. If sym_cnt < 4, write it at bit sym_cnt and increment; otherwise set overflow. Then → SPACE.
  - SPACE: k rises → MARK, before the unit count reaches 3. Unit count reaches 3 → evaluate, → IDLE.
- Evaluation is pure match on (sym_cnt, symbol bits [sym_cnt-1:0]):
  - A: 2, .-
  - B: 4, -...
  - C: 4, -.-.
  - D: 3, -..
  - E: 1, .
  - F: 4, ..-.
  - G: 3, --.
  - H: 4, ....
  - A match loads letter and pulses letter_valid.
  - Overflow or no match pulses letter_error; letter keeps its value.
- Long marks saturate at 7 units and still count as a dash. No timeout in IDLE.

## Timing
- key_in to k: 2 cycles (plus FILTER_CLKS with filter).
- Dot/dash boundary: mark ≥ 2·CLKS_PER_UNIT cycles at k = dash.
- letter_valid/letter_error assert in the cycle the SPACE unit count becomes 3, i.e. 3·CLKS_PER_UNIT cycles after the falling k edge. letter updates in the same cycle.
- Rising k in the cycle the unit count becomes 3: evaluation wins, → IDLE. The new mark is taken from IDLE on the next cycle and is delayed by one cycle.
- letter_valid and letter_error are never both high.
- Reset mid-letter discards the partial symbol and returns to WAIT_LOW. Outputs go to their reset values immediately.

## Configuration
- MORSE_DEC_GLITCH_FILTER_EN defined: k changes only after the synchronized input differs from k for FILTER_CLKS consecutive cycles; shorter pulses are dropped.
- Undefined: k = synchronizer output; FILTER_CLKS is unused.

## Structure
- Shared package holds:
  - state encoding constants (WAIT_LOW, IDLE, MARK, SPACE)
  - letter codes A–H
  - DASH_UNITS=2, LETTER_GAP_UNITS=3, MAX_SYMBOLS=4
  - the pattern/length table consumed by evaluation.
- One sub-module, morse_unit_timer: sub-counter plus saturating unit counter, with a clear input.

## Test plan
All scenarios use CLKS_PER_UNIT=4.
- Send A as the transmitter does (mark 4, space 4, mark 12, space ≥12) → letter=000, letter_valid one pulse 12 cycles after the last falling k edge, busy then 0.
- Send H (four 4-cycle marks, 4-cycle gaps) then C → letter=111 then 010, two valid pulses, no error.
- Boundary: marks of 7 then 8 cycles at k → dot then dash; a 7-cycle single mark decodes E=100, an 8-cycle single mark gives letter_error (T is unsupported).
- Five dots → letter_error pulse, letter unchanged from its previous value.
- Reset asserted mid-mark of B with key_in held high → all outputs 0, no decode until key_in drops. The next clean E gives 100.
- Filter build, FILTER_CLKS=3: 2-cycle key_in glitches during SPACE → ignored, letter decodes normally. Non-filter build: the same glitch is counted as a dot.

Source files
------------

// File: rtl/morse_decoder_pkg.sv
// Shared types, constants and the letter pattern table for the Morse receiver.
// Symbols are stored LSB-first: dot = 0, dash = 1.
package morse_decoder_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    MARK,
    SPACE
  } state_e;

  typedef enum logic [2:0] {
    LTR_A,
    LTR_B,
    LTR_C,
    LTR_D,
    LTR_E,
    LTR_F,
    LTR_G,
    LTR_H
  } letter_e;

  localparam int DASH_UNITS       = 2;
  localparam int LETTER_GAP_UNITS = 3;
  localparam int MAX_SYMBOLS      = 4;

  // Entry i describes letter code i (A at index 0).
  localparam logic [7:0][3:0] PAT_TBL = {
    4'b0000,
    4'b0011,
    4'b0100,
    4'b0000,
    4'b0001,
    4'b0101,
    4'b0001,
    4'b0010
  };

  localparam logic [7:0][2:0] LEN_TBL = {
    3'd4,
    3'd3,
    3'd4,
    3'd1,
    3'd3,
    3'd4,
    3'd4,
    3'd2
  };

  typedef struct packed {
    logic    hit;
    letter_e code;
  } dec_t;

  function automatic dec_t decode(
    input logic [2:0] n,
    input logic [3:0] bits
  );
    dec_t d;
    d.hit  = 1'b0;
    d.code = LTR_A;
    for (int i = 0; i < 8; i++) begin
      if (!d.hit && LEN_TBL[i] == n &&
          PAT_TBL[i] == bits) begin
        d.hit  = 1'b1;
        d.code = letter_e'(i);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/morse_decoder_if.sv
// Key line in, decoded letter and status out.
// master drives the key; slave is the decoder.
interface morse_decoder_if;

  logic       key_in;
  logic [2:0] letter;
  logic       letter_valid;
  logic       letter_error;
  logic       busy;

  modport master (
    output key_in,
    input  letter,
    input  letter_valid,
    input  letter_error,
    input  busy
  );

  modport slave (
    input  key_in,
    output letter,
    output letter_valid,
    output letter_error,
    output busy
  );

endinterface

// File: rtl/morse_unit_timer.sv
// Sub-unit clock counter plus a saturating 3-bit Morse unit counter.
// clr_i restarts timing with the current cycle counted as elapsed.
module morse_unit_timer #(
  parameter int CLKS_PER_UNIT = 25000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  output logic       wrap_o,
  output logic [2:0] units_o
);

  localparam int SW = $clog2(CLKS_PER_UNIT);

  logic [SW-1:0] sub_q, sub_d;
  logic [2:0]    units_q, units_d;

  assign wrap_o  = (sub_q == SW'(CLKS_PER_UNIT - 1));
  assign units_o = units_q;

  // The clear is issued in the cycle after the edge, so that cycle counts.
  always_comb begin
    sub_d   = sub_q + 1'b1;
    units_d = units_q;
    if (clr_i) begin
      sub_d   = SW'(1);
      units_d = '0;
    end else if (wrap_o) begin
      sub_d = '0;
      if (units_q != 3'd7) begin
        units_d = units_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sub_q   <= '0;
      units_q <= '0;
    end else begin
      sub_q   <= sub_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times marks/spaces and decodes letters A-H to 3-bit codes.
// Optional glitch filter: define MORSE_DEC_GLITCH_FILTER_EN.
module morse_decoder
  import morse_decoder_pkg::*;
#(
  parameter int CLKS_PER_UNIT = 25000000,
  parameter int FILTER_CLKS   = 16
) (
  input  logic           CLOCK_50,
  input  logic           Reset,
  morse_decoder_if.slave bus
);

  if (CLKS_PER_UNIT < 2 || FILTER_CLKS < 1) begin : g_cfg_chk
    $error("morse_decoder: bad CLKS_PER_UNIT or FILTER_CLKS");
  end

  // Sync resets to 'mark' so a key held at reset release is not seen low.
  logic [1:0] sync_q;
  logic       k;
  logic       k_prev_q;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.key_in};
    end
  end

`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILTER_CLKS + 1);

  logic [FW-1:0] filt_q;
  logic          kf_q;

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      kf_q   <= 1'b1;
      filt_q <= '0;
    end else if (sync_q[1] == kf_q) begin
      filt_q <= '0;
    end else if (filt_q == FW'(FILTER_CLKS - 1)) begin
      kf_q   <= sync_q[1];
      filt_q <= '0;
    end else begin
      filt_q <= filt_q + 1'b1;
    end
  end

  assign k = kf_q;
`else
  assign k = sync_q[1];
`endif

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      k_prev_q <= 1'b1;
    end else begin
      k_prev_q <= k;
    end
  end

  state_e     state_q, state_d;
  logic [3:0] sym_q, sym_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic [2:0] letter_q, letter_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  logic       tmr_clr;
  logic       unit_wrap;
  logic [2:0] units;
  logic       gap_done;
  dec_t       dec;

  morse_unit_timer #(
    .CLKS_PER_UNIT(CLKS_PER_UNIT)
  ) u_timer (
    .clk_i  (CLOCK_50),
    .rst_i  (Reset),
    .clr_i  (tmr_clr),
    .wrap_o (unit_wrap),
    .units_o(units)
  );

  assign gap_done = unit_wrap &&
    (units == 3'(LETTER_GAP_UNITS - 1));
  assign dec      = decode(cnt_q, sym_q);
  assign tmr_clr  = (k != k_prev_q) ||
    (state_d != state_q);

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      WAIT_LOW: begin
        if (!k) state_d = IDLE;
      end
      // Level test: a mark rising during evaluation is taken here late.
      IDLE: begin
        if (k) begin
          state_d = MARK;
          sym_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      MARK: begin
        if (!k) begin
          state_d = SPACE;
          if (cnt_q < 3'(MAX_SYMBOLS)) begin
            sym_d[cnt_q[1:0]] = (units >= 3'(DASH_UNITS));
            cnt_d = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      SPACE: begin
        if (gap_done) begin
          state_d = IDLE;
          if (!ovf_q && dec.hit) begin
            letter_d = dec.code;
            valid_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (k) begin
          state_d = MARK;
        end
      end
      default: state_d = WAIT_LOW;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q  <= WAIT_LOW;
      sym_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sym_q    <= sym_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign bus.letter       = letter_q;
  assign bus.letter_valid = valid_q;
  assign bus.letter_error = err_q;
  assign bus.busy         = (state_q == MARK) ||
    (state_q == SPACE);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed bench for morse_decoder with CLKS_PER_UNIT=4, FILTER_CLKS=3.
// Expected letter codes and pulse timing are hand-computed.
module tb_morse_decoder;

  localparam int CPU = 4;
  localparam int FC  = 3;
`ifdef MORSE_DEC_GLITCH_FILTER_EN
  localparam int         FILT       = FC;
  localparam logic [2:0] GLITCH_LTR = 3'd3;
`else
  localparam int         FILT       = 0;
  localparam logic [2:0] GLITCH_LTR = 3'd1;
`endif
  // Key drive at negedge P: two sync edges, then 12 clocks of gap.
  localparam int LAT = 14 + FILT;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  morse_decoder_if bus ();

  morse_decoder #(
    .CLKS_PER_UNIT(CPU),
    .FILTER_CLKS  (FC)
  ) dut (
    .CLOCK_50(clk),
    .Reset   (rst),
    .bus     (bus)
  );

  int cyc            = 0;
  int checks         = 0;
  int errors         = 0;
  int n_valid        = 0;
  int n_err          = 0;
  int n_both         = 0;
  int last_valid_cyc = 0;
  int last_fall      = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.letter_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (bus.letter_error) n_err++;
    if (bus.letter_valid && bus.letter_error) n_both++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
        tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    n_valid = 0;
    n_err   = 0;
    n_both  = 0;
  endtask

  task automatic sym(input int on, input int off);
    bus.key_in = 1'b1;
    repeat (on) @(negedge clk);
    bus.key_in = 1'b0;
    last_fall = cyc;
    repeat (off) @(negedge clk);
  endtask

  initial begin
    bus.key_in = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_letter", bus.letter, 0);
    check("rst_valid", bus.letter_valid, 0);
    check("rst_error", bus.letter_error, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // A: .-
    clr_mon();
    sym(4, 4);
    check("a_busy", bus.busy, 1);
    sym(12, 20);
    check("a_letter", bus.letter, 0);
    check("a_valid_n", n_valid, 1);
    check("a_err_n", n_err, 0);
    check("a_latency", last_valid_cyc - last_fall, LAT);
    check("a_busy_end", bus.busy, 0);

    // H then C
    clr_mon();
    repeat (3) sym(4, 4);
    sym(4, 20);
    check("h_letter", bus.letter, 7);
    sym(12, 4);
    sym(4, 4);
    sym(12, 4);
    sym(4, 20);
    check("c_letter", bus.letter, 2);
    check("hc_valid_n", n_valid, 2);
    check("hc_err_n", n_err, 0);

    // dot/dash boundary
    clr_mon();
    sym(7, 20);
    check("e7_letter", bus.letter, 4);
    check("e7_valid_n", n_valid, 1);
    sym(8, 20);
    check("t8_err_n", n_err, 1);
    check("t8_letter", bus.letter, 4);
    check("t8_valid_n", n_valid, 1);

    // five dots overflow
    clr_mon();
    repeat (4) sym(4, 4);
    sym(4, 20);
    check("ovf_err_n", n_err, 1);
    check("ovf_valid_n", n_valid, 0);
    check("ovf_letter", bus.letter, 4);

    // reset mid-letter with key held high
    clr_mon();
    sym(12, 4);
    bus.key_in = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_letter", bus.letter, 0);
    check("mid_valid", bus.letter_valid, 0);
    check("mid_error", bus.letter_error, 0);
    check("mid_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr_mon();
    repeat (30) @(negedge clk);
    check("hold_busy", bus.busy, 0);
    check("hold_valid_n", n_valid, 0);
    check("hold_err_n", n_err, 0);
    bus.key_in = 1'b0;
    repeat (10) @(negedge clk);
    sym(4, 20);
    check("post_letter", bus.letter, 4);
    check("post_valid_n", n_valid, 1);

    // D followed by a 2-cycle glitch in the gap
    clr_mon();
    sym(12, 4);
    sym(4, 4);
    sym(4, 4);
    sym(2, 20);
    check("gl_letter", bus.letter, GLITCH_LTR);
    check("gl_valid_n", n_valid, 1);
    check("gl_err_n", n_err, 0);

    check("never_both", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
